// File: rtl/mem_access_stage.sv
// Memory-access stage: lane-shifts stores, byte-selects and extends loads over a valid/ready data port.
// Latency: 1 cycle for non-memory ops; at least 3 cycles for loads/stores (accept, request, response).
// Backpressure: outStall holds upstream while a transaction is outstanding; request held until dreq_ready.
module mem_access_stage #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        inValid,
  input  logic                        inMemRead,
  input  logic                        inMemWrite,
  input  logic                        inMemOrReg,
  input  logic                        inRegWrite,
  input  logic [4:0]                  inDestReg,
  input  logic [BUS_DATA_WIDTH-1:0]   inResult,
  input  logic [BUS_DATA_WIDTH-1:0]   inStoreData,
  input  logic [2:0]                  inFunct3,
  output logic                        outStall,
  output logic                        dreq_valid,
  output logic                        dreq_write,
  output logic [BUS_DATA_WIDTH-1:0]   dreq_addr,
  output logic [BUS_DATA_WIDTH-1:0]   dreq_wdata,
  output logic [BUS_DATA_WIDTH/8-1:0] dreq_wstrb,
  input  logic                        dreq_ready,
  input  logic                        dresp_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   dresp_rdata,
  output logic                        outValid,
  output logic                        outRegWrite,
  output logic [4:0]                  outDestReg,
  output logic [BUS_DATA_WIDTH-1:0]   outData,
  output logic                        outMisaligned
);
  localparam int LANES = BUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                    state;
  logic [BUS_DATA_WIDTH-1:0] addrQ;
  logic [BUS_DATA_WIDTH-1:0] storeQ;
  logic [2:0]                funct3Q;
  logic [4:0]                destQ;
  logic                      writeQ;
  logic                      regWriteQ;

  logic                      isMem;
  logic                      sizeLegal;
  logic                      aligned;
  logic                      accessOk;
  logic [LANES-1:0]          sizeMask;
  logic [BUS_DATA_WIDTH-1:0] rdShift;
  logic [BUS_DATA_WIDTH-1:0] loadVal;

  // The writeback mux choice is already implied by the mem-op flags here.
  logic unusedMemOrReg;
  assign unusedMemOrReg = inMemOrReg;

  // Classify the incoming instruction: memory op, legal size, natural alignment.
  always_comb begin
    isMem     = inMemRead | inMemWrite;
    sizeLegal = inMemWrite ? ~inFunct3[2] : (inFunct3 != 3'b111);
    case (inFunct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~inResult[0];
      2'b10:   aligned = (inResult[1:0] == 2'b00);
      default: aligned = (inResult[2:0] == 3'b000);
    endcase
    accessOk = sizeLegal & aligned;
  end

  // Drive the request port from latched fields so it stays stable until accepted.
  always_comb begin
    case (funct3Q[1:0])
      2'b00:   sizeMask = 8'h01;
      2'b01:   sizeMask = 8'h03;
      2'b10:   sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
    dreq_valid = (state == REQ);
    dreq_write = dreq_valid & writeQ;
    dreq_addr  = dreq_valid ? {addrQ[BUS_DATA_WIDTH-1:3], 3'b000} : '0;
    dreq_wdata = dreq_write ? (storeQ << {addrQ[2:0], 3'b000}) : '0;
    dreq_wstrb = dreq_write ? (sizeMask << addrQ[2:0]) : '0;
  end

  // Pick the addressed lanes out of the response and extend to the access size.
  always_comb begin
    rdShift = dresp_rdata >> {addrQ[2:0], 3'b000};
    case (funct3Q)
      3'b000:  loadVal = {{(BUS_DATA_WIDTH-8){rdShift[7]}}, rdShift[7:0]};
      3'b001:  loadVal = {{(BUS_DATA_WIDTH-16){rdShift[15]}}, rdShift[15:0]};
      3'b010:  loadVal = {{(BUS_DATA_WIDTH-32){rdShift[31]}}, rdShift[31:0]};
      3'b100:  loadVal = {{(BUS_DATA_WIDTH-8){1'b0}}, rdShift[7:0]};
      3'b101:  loadVal = {{(BUS_DATA_WIDTH-16){1'b0}}, rdShift[15:0]};
      3'b110:  loadVal = {{(BUS_DATA_WIDTH-32){1'b0}}, rdShift[31:0]};
      default: loadVal = rdShift;
    endcase
  end

  assign outStall = (state != IDLE);

  // Transaction FSM with registered writeback outputs; outValid/outMisaligned/outRegWrite pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      addrQ         <= '0;
      storeQ        <= '0;
      funct3Q       <= '0;
      destQ         <= '0;
      writeQ        <= 1'b0;
      regWriteQ     <= 1'b0;
      outValid      <= 1'b0;
      outRegWrite   <= 1'b0;
      outDestReg    <= '0;
      outData       <= '0;
      outMisaligned <= 1'b0;
    end else begin
      outValid      <= 1'b0;
      outRegWrite   <= 1'b0;
      outMisaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            if (!isMem) begin
              outValid    <= 1'b1;
              outRegWrite <= inRegWrite;
              outDestReg  <= inDestReg;
              outData     <= inResult;
            end else if (!accessOk) begin
              outValid      <= 1'b1;
              outMisaligned <= 1'b1;
              outDestReg    <= inDestReg;
            end else begin
              addrQ     <= inResult;
              storeQ    <= inStoreData;
              funct3Q   <= inFunct3;
              destQ     <= inDestReg;
              writeQ    <= inMemWrite;
              regWriteQ <= inRegWrite;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (dreq_ready) state <= WAIT;
        end
        WAIT: begin
          if (dresp_valid) begin
            state       <= IDLE;
            outValid    <= 1'b1;
            outDestReg  <= destQ;
            outRegWrite <= writeQ ? 1'b0 : regWriteQ;
            outData     <= writeQ ? '0 : loadVal;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the RV64IM pipeline, placed between the execute-stage ALU and writeback. It takes the registered EX outputs (result/address, store data, control bits, destination register) and performs loads and stores over a valid/ready data port. Load data is byte-lane selected and sign- or zero-extended, and the stage stalls the upstream pipeline while a memory transaction is outstanding. Registered results go to writeback and back to the forwarding mux as the MEM-stage result.

## Interface
- BUS_DATA_WIDTH, 64, datapath and data-port width; fixed at 64, 8 byte lanes.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inValid  in  1  EX outputs hold a real instruction.
- inMemRead / inMemWrite  in  1  load / store (never both).
- inMemOrReg, inRegWrite  in  1  writeback select / register-write enable.
- inDestReg  in  5  destination register.
- inResult  in  64  ALU result; the effective address for memory ops.
- inStoreData  in  64  rs2 value for stores.
- inFunct3  in  3  access size/sign (RISC-V funct3).
- outStall  out  1  upstream must hold its registers.
- dreq_valid, dreq_write  out  1  request valid; 1 = store.
- dreq_addr  out  64  {inResult[63:3], 3'b000}.
- dreq_wdata  out  64  lane-shifted store data.
- dreq_wstrb  out  8  byte enables.
- dreq_ready  in  1  request accepted.
- dresp_valid  in  1  response (load data or store ack).
- dresp_rdata  in  64  aligned doubleword.
- outValid, outRegWrite  out  1  writeback valid / write enable.
- outDestReg  out  5  destination register.
- outData  out  64  writeback value; also the forwarding MEM result.
- outMisaligned  out  1  misaligned or illegal-size access; one-cycle pulse.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset → IDLE.
- IDLE, inValid with no mem op: on the next edge, outValid=inValid, outRegWrite=inRegWrite, outDestReg=inDestReg, outData=inResult.
- IDLE, inValid with a memory op and aligned legal size: latch the address, store data, funct3, dest, and write flag, then go to REQ. outValid is 0 that edge.
- Alignment rule: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- Size decode for loads:
  - LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110.
  - Loads with funct3=111 are illegal.
  - Stores only use 000–011; any other funct3 on a store is illegal.
- Misaligned or illegal access: no request is issued. Next edge: outValid=1, outMisaligned=1, outRegWrite=0. Stay in IDLE.
- REQ: dreq_valid=1, with all request fields held stable until dreq_ready. The edge with dreq_ready=1 moves to WAIT.
- wstrb: B=0x01, H=0x03, W=0x0F, D=0xFF, each shifted left by addr[2:0]. wdata = storeData << (8*addr[2:0]).
- WAIT: on dresp_valid, register the result and go to IDLE.
  - Load: outData = extend(dresp_rdata >> 8*addr[2:0]) to the access size, sign- or zero-extended. outRegWrite = latched regWrite.
  - Store: outRegWrite=0, outData=0.
  - outValid=1 for one cycle.
- outStall = (state != IDLE), combinational from state only. The held upstream instruction is consumed in the first IDLE cycle.
- dresp_valid outside WAIT is ignored. dreq_ready outside REQ is ignored.

## Timing
- Reset (asynchronous): every output is 0, including dreq_valid and outStall. Any in-flight transaction is abandoned; a late dresp_valid after reset is ignored.
- Non-mem latency: 1 cycle, zero stall.
- Memory op latency: minimum 3 edges (accept → REQ → WAIT → result), with dreq_ready=1 on the first REQ cycle and dresp_valid on the first WAIT cycle. Each extra ready or response wait cycle adds 1.
- outStall rises the cycle after acceptance and falls the cycle after the response edge.
- Back-to-back memory ops: one IDLE cycle between transactions.
- outValid, outMisaligned, outRegWrite, outDestReg, and outData change only on clock edges. outData holds its value until the next outValid.

## Test plan
- ADD pass-through: inValid=1, inResult=0x1234_5678_9ABC_DEF0, inRegWrite=1, dest=5 → next cycle outValid=1, outData=0x123456789ABCDEF0, outStall never asserts.
- LB sign extension: addr 0x1003, rdata=0x0000_0000_8000_0000 → dreq_addr=0x1000, outData=0xFFFF_FFFF_FFFF_FF80. Same access as LBU → 0x80.
- SH with backpressure: addr 0x2006, storeData=0xBEEF, dreq_ready delayed 3 cycles → dreq_wstrb=0xC0, dreq_wdata=0xBEEF_0000_0000_0000 held for 4 cycles, outRegWrite=0, stall covers every cycle.
- Misaligned LW at 0x1002 → no dreq_valid; next cycle outMisaligned=1, outValid=1, outRegWrite=0.
- Reset asserted in WAIT → dreq_valid and outStall drop immediately, state is IDLE. A stale dresp_valid after release does not produce outValid.
- Back-to-back LD 0x3000 then LWU 0x3004 (rdata=0xFFFF_FFFF_1111_1111) → results 0xFFFFFFFF11111111 then 0x00000000FFFFFFFF, with one IDLE cycle between requests.
